// File: rtl/cordic_pkg.sv
// Shared constants, state type and angle helpers for the CORDIC sweep front end.
package cordic_pkg;

   localparam int         DEG_FULL   = 32'sd360;
   localparam int         CORDIC_LAT = 32'sd16;
   localparam logic [9:0] DEG_FULL_W = 10'd360;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sweep_state_e;

   // Advance an angle by step and fold once into 0..359; both operands are below 360.
   function automatic logic [8:0] deg_wrap_add(input logic [8:0] cur, input logic [8:0] step);
      logic [9:0] sum;
      logic [9:0] wrapped;
      sum     = {1'b0, cur} + {1'b0, step};
      wrapped = sum - DEG_FULL_W;
      return (sum >= DEG_FULL_W) ? wrapped[8:0] : sum[8:0];
   endfunction

   function automatic logic deg_in_range(input logic [8:0] angle);
      return ({1'b0, angle} < DEG_FULL_W);
   endfunction

endpackage

// File: rtl/cordic_valid_delay.sv
// Sample-valid and last-sample tag delay lines matching the CORDIC pipeline depth.
module cordic_valid_delay
#(
   parameter int LAT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic valid_in,
   input  logic last_in,
   output logic x_valid,
   output logic x_last
);

   logic [LAT-1:0] valid_r;
   logic [LAT-1:0] last_r;
   logic [LAT-1:0] valid_next_s;
   logic [LAT-1:0] last_next_s;

   generate
      if (LAT == 1) begin : g_single
         assign valid_next_s = valid_in;
         assign last_next_s  = last_in;
      end else begin : g_multi
         assign valid_next_s = {valid_r[LAT-2:0], valid_in};
         assign last_next_s  = {last_r[LAT-2:0], last_in};
      end
   endgenerate

   // One stage per clock; clear drops every in-flight sample at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_r <= {LAT{1'b0}};
         last_r  <= {LAT{1'b0}};
      end else if (clear) begin
         valid_r <= {LAT{1'b0}};
         last_r  <= {LAT{1'b0}};
      end else begin
         valid_r <= valid_next_s;
         last_r  <= last_next_s;
      end
   end

   assign x_valid = valid_r[LAT-1];
   assign x_last  = last_r[LAT-1];

endmodule

// File: rtl/cordic_sweep_gen.sv
// Integer-degree angle sweep generator feeding the CORDIC sin/cos pipeline.
module cordic_sweep_gen
   import cordic_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int LAT   = CORDIC_LAT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [8:0]         cfg_start,
   input  logic [8:0]         cfg_step,
   input  logic [CNT_W-1:0]   cfg_count,
   input  logic               abort,
   output logic signed [31:0] deg,
   output logic               deg_valid,
   output logic               x_valid,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   sweep_state_e     state_r;
   sweep_state_e     state_next_s;
   logic [8:0]       deg_r;
   logic [8:0]       step_r;
   logic [CNT_W-1:0] remain_r;
   logic             deg_valid_r;
   logic             cfg_ready_r;
   logic             busy_r;
   logic             zero_done_r;
   logic             cfg_err_r;

   logic             handshake_s;
   logic             desc_bad_s;
   logic             desc_zero_s;
   logic             start_s;
   logic             kill_s;
   logic             last_s;
   logic             x_valid_s;
   logic             x_last_s;

   assign handshake_s = cfg_valid && (state_r == IDLE);
   assign desc_bad_s  = !deg_in_range(cfg_start) || !deg_in_range(cfg_step);
   assign desc_zero_s = (cfg_count == CNT_ZERO);
   assign start_s     = handshake_s && !desc_bad_s && !desc_zero_s;
   assign kill_s      = abort && (state_r != IDLE);
   // remain_r counts samples still to come after the one on deg this cycle.
   assign last_s      = (state_r == RUN) && (remain_r == CNT_ZERO);

   // Sweep sequencing: abort beats both the final sample and the drain completion.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_next_s = IDLE;
            end else if (remain_r == CNT_ZERO) begin
               state_next_s = DRAIN;
            end else begin
               state_next_s = RUN;
            end
         end
         DRAIN: begin
            if (abort || x_last_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DRAIN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Angle accumulator and remaining-sample counter; deg holds once the sweep stops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         deg_r       <= 9'd0;
         step_r      <= 9'd0;
         remain_r    <= CNT_ZERO;
         deg_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  deg_r       <= cfg_start;
                  step_r      <= cfg_step;
                  remain_r    <= cfg_count - CNT_ONE;
                  deg_valid_r <= 1'b1;
               end else begin
                  deg_valid_r <= 1'b0;
               end
            end
            RUN: begin
               if (abort || (remain_r == CNT_ZERO)) begin
                  deg_valid_r <= 1'b0;
               end else begin
                  deg_r       <= deg_wrap_add(deg_r, step_r);
                  remain_r    <= remain_r - CNT_ONE;
                  deg_valid_r <= 1'b1;
               end
            end
            default: begin
               deg_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Handshake status and descriptor-outcome pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cfg_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         zero_done_r <= 1'b0;
         cfg_err_r   <= 1'b0;
      end else begin
         cfg_ready_r <= (state_next_s == IDLE);
         busy_r      <= (state_next_s != IDLE);
         zero_done_r <= handshake_s && !desc_bad_s && desc_zero_s;
         cfg_err_r   <= handshake_s && desc_bad_s;
      end
   end

   cordic_valid_delay #(
      .LAT (LAT)
   ) u_valid_delay (
      .clock    (clock),
      .reset    (reset),
      .clear    (kill_s),
      .valid_in (deg_valid_r),
      .last_in  (last_s),
      .x_valid  (x_valid_s),
      .x_last   (x_last_s)
   );

   assign deg       = $signed({23'd0, deg_r});
   assign deg_valid = deg_valid_r;
   assign x_valid   = x_valid_s;
   assign cfg_ready = cfg_ready_r;
   assign busy      = busy_r;
   assign cfg_err   = cfg_err_r;
   // Both sources are flops; the zero-count pulse and a drain completion never coincide.
   assign done      = zero_done_r | x_last_s;

endmodule

// File: tb/tb_cordic_sweep_gen.sv
// Randomized self-checking bench for cordic_sweep_gen against a closed-form sweep model.
module tb_cordic_sweep_gen;

   localparam int CNT_W = 16;
   localparam int LAT   = 16;

   logic               clock = 1'b0;
   logic               reset;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [8:0]         cfg_start;
   logic [8:0]         cfg_step;
   logic [CNT_W-1:0]   cfg_count;
   logic               abort;
   logic signed [31:0] deg;
   logic               deg_valid;
   logic               x_valid;
   logic               busy;
   logic               done;
   logic               cfg_err;

   int checks = 0;
   int errors = 0;
   int model_deg = 0;
   bit deg_known = 1'b1;

   cordic_sweep_gen #(
      .CNT_W (CNT_W),
      .LAT   (LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_start (cfg_start),
      .cfg_step  (cfg_step),
      .cfg_count (cfg_count),
      .abort     (abort),
      .deg       (deg),
      .deg_valid (deg_valid),
      .x_valid   (x_valid),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_values();
      check_value("rst_deg", int'(deg), 0);
      check_value("rst_deg_valid", int'(deg_valid), 0);
      check_value("rst_x_valid", int'(x_valid), 0);
      check_value("rst_busy", int'(busy), 0);
      check_value("rst_done", int'(done), 0);
      check_value("rst_cfg_err", int'(cfg_err), 0);
      check_value("rst_cfg_ready", int'(cfg_ready), 1);
   endtask

   // Entered and left on a falling edge. abort_at/pulse_at = 0 means unused.
   task automatic run_sweep(input int start, input int step, input int count,
                            input int abort_at, input int pulse_at);
      bit bad;
      bit zero;
      bit ab;
      int last_deg;
      int t_end;
      bad  = (start >= 360) || (step >= 360);
      zero = (count == 0);
      check_value("ready_pre", int'(cfg_ready), 1);
      cfg_valid = 1'b1;
      cfg_start = start[8:0];
      cfg_step  = step[8:0];
      cfg_count = count[CNT_W-1:0];
      @(posedge clock);
      @(negedge clock);
      cfg_valid = 1'b0;
      if (bad || zero) begin
         for (int t = 1; t <= 3; t++) begin
            check_value("cfg_err", int'(cfg_err), int'(t == 1 && bad));
            check_value("done_zero", int'(done), int'(t == 1 && !bad));
            check_value("dv_idle", int'(deg_valid), 0);
            check_value("xv_idle", int'(x_valid), 0);
            check_value("busy_idle", int'(busy), 0);
            check_value("ready_idle", int'(cfg_ready), 1);
            if (deg_known) check_value("deg_held", int'(deg), model_deg);
            @(posedge clock);
            @(negedge clock);
         end
      end else begin
         last_deg = (start + (count - 1) * step) % 360;
         t_end    = count + LAT + 3;
         for (int t = 1; t <= t_end; t++) begin
            ab = (abort_at > 0) && (t > abort_at);
            check_value("deg_valid", int'(deg_valid), int'(!ab && t <= count));
            check_value("x_valid", int'(x_valid), int'(!ab && t > LAT && (t - LAT) <= count));
            check_value("done", int'(done), int'(!ab && t == count + LAT));
            check_value("busy", int'(busy), int'(!ab && t <= count + LAT));
            check_value("cfg_ready", int'(cfg_ready), int'(ab || t > count + LAT));
            check_value("cfg_err", int'(cfg_err), 0);
            if (!ab && t <= count) begin
               check_value("deg", int'(deg), (start + (t - 1) * step) % 360);
            end else if (!ab) begin
               check_value("deg_hold", int'(deg), last_deg);
            end
            abort = (t == abort_at);
            if (t == pulse_at) begin
               cfg_valid = 1'b1;
               cfg_start = 9'($urandom_range(359, 0));
               cfg_step  = 9'($urandom_range(359, 0));
               cfg_count = CNT_W'($urandom_range(20, 0));
            end else begin
               cfg_valid = 1'b0;
            end
            @(posedge clock);
            @(negedge clock);
         end
         abort     = 1'b0;
         cfg_valid = 1'b0;
         if (abort_at > 0) begin
            deg_known = 1'b0;
         end else begin
            model_deg = last_deg;
            deg_known = 1'b1;
         end
      end
   endtask

   initial begin
      int s;
      int st;
      int n;
      int a;
      int p;
      reset     = 1'b1;
      cfg_valid = 1'b0;
      cfg_start = 9'd0;
      cfg_step  = 9'd0;
      cfg_count = {CNT_W{1'b0}};
      abort     = 1'b0;
      #1;
      check_reset_values();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      run_sweep(350, 5, 4, 0, 2);
      run_sweep(90, 0, 3, 0, 0);
      run_sweep(200, 10, 0, 0, 0);
      run_sweep(360, 5, 4, 0, 0);
      run_sweep(10, 400, 4, 0, 0);
      run_sweep(355, 5, 2, 0, 0);
      run_sweep(30, 40, 10, 3, 0);
      run_sweep(1, 359, 5, 5 + 8, 0);

      for (int i = 0; i < 10; i++) begin
         s  = $urandom_range(359, 0);
         st = $urandom_range(359, 0);
         n  = $urandom_range(20, 1);
         a  = ($urandom_range(2, 0) == 0) ? $urandom_range(n + LAT - 1, 1) : 0;
         p  = $urandom_range(n, 1);
         if (a > 0 && p > a) p = a;
         run_sweep(s, st, n, a, p);
      end
      run_sweep($urandom_range(511, 360), $urandom_range(359, 0), 5, 0, 0);

      // Reset landing in DRAIN must flush every output and the in-flight samples.
      cfg_valid = 1'b1;
      cfg_start = 9'd100;
      cfg_step  = 9'd7;
      cfg_count = 16'd3;
      @(posedge clock);
      @(negedge clock);
      cfg_valid = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock);
      check_value("busy_drain", int'(busy), 1);
      check_value("dv_drain", int'(deg_valid), 0);
      check_value("deg_drain", int'(deg), 114);
      reset = 1'b1;
      #1;
      check_reset_values();
      @(posedge clock);
      @(negedge clock);
      reset     = 1'b0;
      model_deg = 0;
      deg_known = 1'b1;
      @(negedge clock);
      run_sweep(0, 1, 2, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cordic_sweep_gen.md
# cordic_sweep_gen

Angle-sweep generator sitting directly upstream of the CORDIC sine/cosine pipeline. It accepts a sweep descriptor (start angle, step, sample count) via a valid/ready handshake and emits one integer-degree angle per clock on `deg`. It also produces `x_valid`, a copy of the sample-valid delayed by the CORDIC latency, so downstream logic knows which `Xout` words are real samples.

## Interface
- `CNT_W`, default 16: width of the sample counter and `cfg_count`.
- `LAT`, default 16: CORDIC pipeline latency in clocks, from `deg` sampled to `Xout` valid.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: sweep descriptor present.
- `cfg_ready` out 1: high only in IDLE.
- `cfg_start` in 9: first angle, in degrees; legal range 0..359.
- `cfg_step` in 9: per-sample increment, in degrees; legal range 0..359.
- `cfg_count` in CNT_W: number of samples to emit.
- `abort` in 1: cancels a sweep in RUN or DRAIN.
- `deg` out 32, signed: angle to the CORDIC `deg` input, zero-extended from 9 bits.
- `deg_valid` out 1: `deg` carries a sample this cycle.
- `x_valid` out 1: `deg_valid` delayed by exactly LAT cycles.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the last sample's `x_valid` is asserted.
- `cfg_err` out 1: one-cycle pulse when a descriptor is rejected.

## Operation
States:
- IDLE
  - `cfg_ready`=1.
  - On a handshake (`cfg_valid` and `cfg_ready`):
    - If `cfg_start`≥360 or `cfg_step`≥360: pulse `cfg_err` the next cycle and stay in IDLE.
    - Else if `cfg_count`==0: pulse `done` the next cycle and stay in IDLE.
    - Else: latch step and count, load `deg`=`cfg_start`, and go to RUN.
- RUN
  - `deg_valid`=1 every cycle. There is no backpressure, because the CORDIC has none.
  - Each cycle: next = cur + step (10-bit add). If next ≥ 360, subtract 360. Both operands are below 360, so one subtraction always suffices.
  - The remaining-count register decrements each cycle. After the final sample, go to DRAIN.
- DRAIN
  - `deg_valid`=0, and `deg` holds the last emitted value.
  - Wait until the final sample's `x_valid` appears. Assert `done` in that same cycle, then go to IDLE.

Boundary and concurrency rules:
- `cfg_valid` while busy is ignored, because `cfg_ready`=0.
- `abort` in RUN or DRAIN:
  - Next cycle: IDLE, `deg_valid`=0, and the whole `x_valid` delay line is cleared.
  - No `done` is issued.
  - `abort` in IDLE has no effect.
- Simultaneous `abort` and the final-sample cycle: abort wins, and no `done` is issued.
- `step`=0 emits `cfg_start` repeatedly. Wrap to 0 is legal, e.g. 355+5 → 0.
- Reset, asynchronous and valid at any time including mid-sweep: every output goes to its reset value and the delay line is cleared.
  - All outputs reset to 0 except `cfg_ready`, which resets to 1.
  - `deg` resets to 0.

## Timing
- Handshake at edge k → first sample `deg_valid`=1 with `deg`=`cfg_start` in the cycle after edge k.
- Samples are contiguous: sample n occupies cycle k+1+n.
- `x_valid` for sample n is asserted in cycle k+1+n+LAT. `done` coincides with `x_valid` of sample count−1.
- `cfg_ready` rises in the cycle after `done`, so a back-to-back descriptor can be accepted then.
- `cfg_err` and the zero-count `done` are asserted in the cycle after the handshake edge.
- Minimum idle-to-idle time for count N is N+LAT+1 cycles.

## Structure
- The shared package `cordic_pkg` holds:
  - constant `DEG_FULL`=360;
  - constant `CORDIC_LAT`=16, which is the default for LAT;
  - the state enum {IDLE, RUN, DRAIN}.
- Sub-module `cordic_valid_delay`: LAT-deep, 1-bit shift register with a synchronous clear (driven by abort) plus the asynchronous reset. It provides `x_valid` and a "last-sample" tag bit that is delayed alongside it.
- Top level: FSM, angle accumulator with modulo-360 wrap, and counter.

## Test plan
- start=350, step=5, count=4:
  - `deg` = 350, 355, 0, 5 on consecutive cycles after the handshake.
  - `x_valid` high exactly 16 cycles later, for 4 cycles.
  - `done` coincides with the 4th `x_valid`.
- start=90, step=0, count=3: `deg`=90 for three cycles, then `deg_valid` drops and `deg` holds 90 through DRAIN.
- count=0: no `deg_valid`, no `x_valid`, `done` one cycle after the handshake, `busy` never asserted.
- start=360 (and separately step=400 mod 512): `cfg_err` pulses once, the state stays IDLE, and `deg` stays unchanged.
- count=10 with `abort` asserted after 3 samples:
  - `deg_valid`=0 next cycle.
  - No `x_valid` after abort (the 3 in-flight samples are cleared).
  - No `done`; `busy`=0 and `cfg_ready`=1 next cycle.
- `cfg_valid` pulsed during RUN is ignored. Reset asserted mid-DRAIN forces all outputs to their reset values immediately. After reset release, a new descriptor (start=0, step=1, count=2) yields 0, 1.
